// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one read per cycle to a single-cycle-latency
// instruction memory and delivers words through an output register backed by
// a one-entry skid buffer. Redirect flushes the pipe; halt stops fetching and
// lets already-fetched words drain.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_ena,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out
);

  localparam logic [31:0] PcStep = 32'(PC_STEP);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalted
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;

  // Request issued last cycle; its data is on imem_instr this cycle.
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic        w_inflight_nxt;
  logic [31:0] w_inflight_pc_nxt;

  logic        r_skid_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic        w_skid_valid_nxt;
  logic [31:0] w_skid_instr_nxt;
  logic [31:0] w_skid_pc_nxt;

  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_pc;
  logic        w_out_valid_nxt;
  logic [31:0] w_out_instr_nxt;
  logic [31:0] w_out_pc_nxt;

  logic        w_flush;
  logic        w_fetch;

  // Redirect is honoured in IDLE and RUN only; once halted it is ignored.
  assign w_flush = redirect && (r_state != StHalted);

  // Fetch only in RUN with nothing blocking; the skid term keeps a full skid
  // from ever being overrun while decode is stalled.
  assign w_fetch = (r_state == StRun) && !stall && !redirect && !halt &&
                   !(r_skid_valid && stall);

  assign imem_ena    = w_fetch;
  assign imem_pc     = r_pc;
  assign instr_valid = r_out_valid;
  assign instr_out   = r_out_instr;
  assign pc_out      = r_out_pc;

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: IDLE lasts one cycle; halt is sticky until reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (redirect && halt) begin
          w_state_nxt = StHalted;
        end else begin
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        if (halt) begin
          w_state_nxt = StHalted;
        end
      end
      StHalted: begin
        w_state_nxt = StHalted;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // PC and in-flight tracking: redirect wins over sequential advance.
  always_comb begin
    w_pc_nxt          = r_pc;
    w_inflight_nxt    = w_fetch;
    w_inflight_pc_nxt = r_inflight_pc;
    if (w_flush) begin
      w_pc_nxt       = redirect_pc;
      w_inflight_nxt = 1'b0;
    end else if (w_fetch) begin
      w_pc_nxt          = r_pc + PcStep;
      w_inflight_pc_nxt = r_pc;
    end
  end

  // Output register / skid buffer steering for returning and buffered words.
  always_comb begin
    w_skid_valid_nxt = r_skid_valid;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc_nxt    = r_skid_pc;
    w_out_valid_nxt  = r_out_valid;
    w_out_instr_nxt  = r_out_instr;
    w_out_pc_nxt     = r_out_pc;
    if (w_flush) begin
      // Returning word (if any) is dropped along with everything buffered.
      w_skid_valid_nxt = 1'b0;
      w_out_valid_nxt  = 1'b0;
    end else if (!stall) begin
      if (r_skid_valid) begin
        // Oldest word is in the skid; a returning word refills the slot.
        w_out_valid_nxt  = 1'b1;
        w_out_instr_nxt  = r_skid_instr;
        w_out_pc_nxt     = r_skid_pc;
        w_skid_valid_nxt = r_inflight;
        if (r_inflight) begin
          w_skid_instr_nxt = imem_instr;
          w_skid_pc_nxt    = r_inflight_pc;
        end
      end else if (r_inflight) begin
        w_out_valid_nxt = 1'b1;
        w_out_instr_nxt = imem_instr;
        w_out_pc_nxt    = r_inflight_pc;
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end else if (r_inflight) begin
      // Stalled: an empty output may still be filled, otherwise park in skid.
      if (!r_out_valid) begin
        w_out_valid_nxt = 1'b1;
        w_out_instr_nxt = imem_instr;
        w_out_pc_nxt    = r_inflight_pc;
      end else if (!r_skid_valid) begin
        w_skid_valid_nxt = 1'b1;
        w_skid_instr_nxt = imem_instr;
        w_skid_pc_nxt    = r_inflight_pc;
      end
    end
  end

  // Datapath registers; reset discards all in-flight and buffered words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
      r_skid_valid  <= 1'b0;
      r_skid_instr  <= 32'h0;
      r_skid_pc     <= 32'h0;
      r_out_valid   <= 1'b0;
      r_out_instr   <= 32'h0;
      r_out_pc      <= 32'h0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_inflight    <= w_inflight_nxt;
      r_inflight_pc <= w_inflight_pc_nxt;
      r_skid_valid  <= w_skid_valid_nxt;
      r_skid_instr  <= w_skid_instr_nxt;
      r_skid_pc     <= w_skid_pc_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_instr   <= w_out_instr_nxt;
      r_out_pc      <= w_out_pc_nxt;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter PC_STEP, default 4, meaning the PC increment per issued fetch.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port imem_ena  output  1  instruction-memory read enable, one request per cycle high.
REQ-006 The block SHALL have port imem_pc  output  32  instruction-memory read address.
REQ-007 The block SHALL have port imem_instr  input  32  memory read data, valid exactly one cycle after the request cycle.
REQ-008 The block SHALL have port stall  input  1  decode not ready; output held while high.
REQ-009 The block SHALL have port redirect  input  1  taken branch/jump; one-cycle pulse.
REQ-010 The block SHALL have port redirect_pc  input  32  target address, sampled when redirect=1.
REQ-011 The block SHALL have port halt  input  1  stop issuing fetches until reset.
REQ-012 The block SHALL have port instr_valid  output  1  instr_out/pc_out hold a fetched instruction.
REQ-013 The block SHALL have port instr_out  output  32  fetched instruction word.
REQ-014 The block SHALL have port pc_out  output  32  address of instr_out.

Function
REQ-015 The state machine SHALL have states IDLE, RUN and HALTED; reset enters IDLE; IDLE -> RUN unconditionally after one cycle.
REQ-016 imem_ena SHALL be combinational: 1 iff state=RUN and stall=0 and redirect=0 and halt=0 and skid buffer not full with stall=1.
REQ-017 imem_pc SHALL equal the PC register; the PC SHALL advance by PC_STEP (mod 2^32, wrap-around, no flag) on every cycle with imem_ena=1.
REQ-018 The block SHALL track one in-flight request flag, set on the cycle imem_ena=1, and capture imem_instr with its address on the following cycle.
REQ-019 A returning word SHALL load the output register if instr_valid=0 or stall=0, otherwise the one-entry skid buffer.
REQ-020 When stall=0 and the skid buffer is full, the output register SHALL load from the skid buffer, emptying it; a word returning that same cycle goes into the emptied skid slot.
REQ-021 instr_valid SHALL drop to 0 when stall=0 and no word (skid or returning) is available; while stall=1, instr_out/pc_out/instr_valid SHALL be held unchanged.
REQ-022 A word delivered with stall=0 and instr_valid=1 SHALL count as consumed exactly once; no word SHALL be duplicated or dropped.
REQ-023 redirect=1 (state RUN or IDLE) SHALL load PC with redirect_pc, discard any in-flight response, clear skid buffer and instr_valid next cycle; redirect overrides stall.
REQ-024 The first fetch after redirect SHALL issue the cycle after the redirect pulse at redirect_pc.
REQ-025 halt=1 with redirect=0 SHALL move RUN -> HALTED; in-flight and buffered words still drain normally; HALTED ignores redirect and stall except for draining.
REQ-026 Simultaneous redirect and halt SHALL apply the redirect (PC load, flush) and enter HALTED.

Reset
REQ-027 rst=0 SHALL asynchronously force PC=RESET_PC, state=IDLE, in-flight flag=0, skid empty, instr_valid=0, instr_out=0, pc_out=0; imem_ena SHALL be 0 during reset.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight and buffered words; the first fetch after release is at RESET_PC in the second cycle after rst rises.

Verification
REQ-029 Release reset, stall=0, memory returns addr-tagged words -> imem_ena first high in cycle 2 at PC 0, instr_valid from cycle 3, pc_out 0,4,8,... every cycle.
REQ-030 Assert stall for 3 cycles while streaming -> output held, one word lands in skid, no further imem_ena; after release pc_out continues with no gap or duplicate.
REQ-031 redirect pulse with redirect_pc=32'h100 while a fetch is in flight -> in-flight word dropped, next imem_pc=32'h100, next valid pc_out=32'h100.
REQ-032 halt asserted at PC 32'h20 -> imem_ena stays 0 forever, last in-flight word delivered, instr_valid falls; redirect afterwards has no effect.
REQ-033 PC at 32'hFFFF_FFFC issues a fetch -> next imem_pc=32'h0000_0000.
REQ-034 rst pulled low mid-stream with stall=1 and skid full -> all outputs 0 immediately; after release fetching restarts at RESET_PC.
